// File: rtl/ma_pma_region_checker.sv
// Programmable PMA region checker: register port programs NR_REGIONS address windows,
// a two-stage back-pressured lookup pipeline classifies physical addresses against them.
module ma_pma_region_checker #(
    parameter int         NR_REGIONS   = 4,
    parameter int         ADDR_WIDTH   = 64,
    parameter logic [2:0] DEFAULT_ATTR = 3'b000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [7:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic                  cfg_rvalid_o,
    output logic [31:0]           cfg_rdata_o,
    output logic                  cfg_err_o,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_kind_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [2:0]            rsp_region_o,
    output logic                  rsp_cached_o,
    output logic                  rsp_nonidem_o,
    output logic                  rsp_exec_o,
    output logic                  rsp_fault_o
);
    localparam int         HI_W     = ADDR_WIDTH - 32;
    localparam logic [7:0] FCNT_IDX = 8'(NR_REGIONS * 8);

    logic [63:0]               base_ext [NR_REGIONS];
    logic [63:0]               len_ext  [NR_REGIONS];
    logic [NR_REGIONS-1:0]     lock_vec;
    logic [NR_REGIONS-1:0]     en_vec;
    logic [3*NR_REGIONS-1:0]   attr_flat;
    logic [NR_REGIONS-1:0]     match_vec;
    logic [NR_REGIONS-1:0]     region_sel;

    logic        is_fcnt;
    logic        cfg_err_next;
    logic        cfg_wr_ok;
    logic [31:0] cfg_rdata_next;
    logic [31:0] fault_cnt_reg;

    logic                    s1_valid_reg;
    logic [NR_REGIONS-1:0]   s1_match_reg;
    logic [3*NR_REGIONS-1:0] s1_attr_reg;
    logic [1:0]              s1_kind_reg;

    logic       advance;
    logic       enc_hit;
    logic [2:0] enc_region;
    logic [2:0] enc_attr;
    logic       enc_fault;
    logic       fault_inc;

    assign is_fcnt      = (cfg_addr_i == FCNT_IDX);
    assign cfg_err_next = cfg_req_i && (!(|region_sel || is_fcnt) || (cfg_we_i && |(region_sel & lock_vec)));
    assign cfg_wr_ok    = cfg_req_i && cfg_we_i && !cfg_err_next;

    generate
        for (genvar gi = 0; gi < NR_REGIONS; gi++) begin : g_region
            logic [ADDR_WIDTH-1:0] base_reg;
            logic [ADDR_WIDTH-1:0] len_reg;
            logic                  lock_reg;
            logic                  en_reg;
            logic [2:0]            attr_reg;
            logic [ADDR_WIDTH:0]   lo_ext;
            logic [ADDR_WIDTH:0]   hi_ext;
            logic [ADDR_WIDTH:0]   addr_ext;
            logic                  wr_this;

            assign region_sel[gi] = (cfg_addr_i < FCNT_IDX) && (cfg_addr_i[7:3] == 5'(gi))
                                    && (cfg_addr_i[2:0] <= 3'd4);
            assign wr_this = cfg_wr_ok && region_sel[gi];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    base_reg <= '0;
                    len_reg  <= '0;
                    lock_reg <= 1'b0;
                    en_reg   <= 1'b0;
                    attr_reg <= '0;
                end else if (wr_this) begin
                    case (cfg_addr_i[2:0])
                        3'd0: base_reg[31:0]            <= cfg_wdata_i;
                        3'd1: base_reg[ADDR_WIDTH-1:32] <= cfg_wdata_i[HI_W-1:0];
                        3'd2: len_reg[31:0]             <= cfg_wdata_i;
                        3'd3: len_reg[ADDR_WIDTH-1:32]  <= cfg_wdata_i[HI_W-1:0];
                        default: begin
                            lock_reg <= cfg_wdata_i[31];
                            en_reg   <= cfg_wdata_i[3];
                            attr_reg <= cfg_wdata_i[2:0];
                        end
                    endcase
                end
            end

            // One extra bit so a window ending at 2^ADDR_WIDTH still covers the top address.
            assign lo_ext   = {1'b0, base_reg};
            assign hi_ext   = lo_ext + {1'b0, len_reg};
            assign addr_ext = {1'b0, req_addr_i};
            assign match_vec[gi] = en_reg && (len_reg != '0) && (addr_ext >= lo_ext) && (addr_ext < hi_ext);

            assign base_ext[gi]          = 64'(base_reg);
            assign len_ext[gi]           = 64'(len_reg);
            assign lock_vec[gi]          = lock_reg;
            assign en_vec[gi]            = en_reg;
            assign attr_flat[gi*3 +: 3]  = attr_reg;
        end
    endgenerate

    always_comb begin
        cfg_rdata_next = '0;
        if (cfg_req_i && !cfg_we_i && !cfg_err_next) begin
            if (is_fcnt) cfg_rdata_next = fault_cnt_reg;
            for (int r = 0; r < NR_REGIONS; r++) begin
                if (region_sel[r]) begin
                    case (cfg_addr_i[2:0])
                        3'd0:    cfg_rdata_next = base_ext[r][31:0];
                        3'd1:    cfg_rdata_next = base_ext[r][63:32];
                        3'd2:    cfg_rdata_next = len_ext[r][31:0];
                        3'd3:    cfg_rdata_next = len_ext[r][63:32];
                        default: cfg_rdata_next = {lock_vec[r], 27'b0, en_vec[r], attr_flat[r*3 +: 3]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_rdata_o  <= cfg_rdata_next;
            cfg_err_o    <= cfg_err_next;
        end
    end

    // Clearing write takes priority over a same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_cnt_reg <= '0;
        end else if (cfg_wr_ok && is_fcnt) begin
            fault_cnt_reg <= '0;
        end else if (fault_inc && (fault_cnt_reg != 32'hFFFF_FFFF)) begin
            fault_cnt_reg <= fault_cnt_reg + 32'd1;
        end
    end

    assign advance     = !rsp_valid_o || rsp_ready_i;
    assign req_ready_o = advance;

    always_comb begin
        enc_hit    = 1'b0;
        enc_region = 3'd0;
        enc_attr   = DEFAULT_ATTR;
        for (int r = NR_REGIONS - 1; r >= 0; r--) begin
            if (s1_match_reg[r]) begin
                enc_hit    = 1'b1;
                enc_region = 3'(r);
                enc_attr   = s1_attr_reg[r*3 +: 3];
            end
        end
        enc_fault = ((s1_kind_reg == 2'd2) && !enc_attr[2]) || ((s1_kind_reg == 2'd3) && enc_attr[1]);
    end

    assign fault_inc = advance && s1_valid_reg && enc_fault;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_reg  <= 1'b0;
            s1_match_reg  <= '0;
            s1_attr_reg   <= '0;
            s1_kind_reg   <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            rsp_region_o  <= '0;
            rsp_cached_o  <= 1'b0;
            rsp_nonidem_o <= 1'b0;
            rsp_exec_o    <= 1'b0;
            rsp_fault_o   <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= req_valid_i;
            s1_match_reg <= match_vec;
            s1_attr_reg  <= attr_flat;
            s1_kind_reg  <= req_kind_i;
            rsp_valid_o  <= s1_valid_reg;
            if (s1_valid_reg) begin
                rsp_hit_o     <= enc_hit;
                rsp_region_o  <= enc_region;
                rsp_cached_o  <= enc_attr[0];
                rsp_nonidem_o <= enc_attr[1];
                rsp_exec_o    <= enc_attr[2];
                rsp_fault_o   <= enc_fault;
            end
        end
    end
endmodule

// File: tb/tb_ma_pma_region_checker.sv
// Directed bench for ma_pma_region_checker: register programming, lookups, locking,
// fault counting, back-pressure and mid-operation reset against hand-computed values.
module tb_ma_pma_region_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;
    logic        cfg_err;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_kind = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_hit;
    logic [2:0]  rsp_region;
    logic        rsp_cached, rsp_nonidem, rsp_exec, rsp_fault;

    int n_vec = 0;
    int n_err = 0;

    ma_pma_region_checker #(.NR_REGIONS(4), .ADDR_WIDTH(64), .DEFAULT_ATTR(3'b000)) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_kind_i(req_kind),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit), .rsp_region_o(rsp_region),
        .rsp_cached_o(rsp_cached), .rsp_nonidem_o(rsp_nonidem), .rsp_exec_o(rsp_exec), .rsp_fault_o(rsp_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rsp_pack();
        return {rsp_hit, rsp_region, rsp_exec, rsp_nonidem, rsp_cached, rsp_fault};
    endfunction

    // Expected response word: {hit, region[2:0], exec, nonidem, cached, fault}
    function automatic logic [7:0] mk(logic hit, logic [2:0] reg_idx, logic [2:0] attr, logic fault);
        return {hit, reg_idx, attr, fault};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic cfg_write(input string tag, input logic [7:0] idx, input logic [31:0] data, input logic exp_err);
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = idx; cfg_wdata = data;
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_we = 1'b0;
        check({tag, " rvalid"}, 64'(cfg_rvalid), 64'd1);
        check({tag, " err"}, 64'(cfg_err), 64'(exp_err));
    endtask

    task automatic cfg_read(input string tag, input logic [7:0] idx, input logic [31:0] exp_data, input logic exp_err);
        @(posedge clk); #1;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = idx;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        check({tag, " rvalid"}, 64'(cfg_rvalid), 64'd1);
        check({tag, " rdata"}, 64'(cfg_rdata), 64'(exp_data));
        check({tag, " err"}, 64'(cfg_err), 64'(exp_err));
    endtask

    // Single lookup with rsp_ready held high; checks the t+2 response latency.
    task automatic lookup(input string tag, input logic [63:0] addr, input logic [1:0] kind, input logic [7:0] exp);
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = addr; req_kind = kind;
        check({tag, " ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " t+1 valid"}, 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        check({tag, " t+2 valid"}, 64'(rsp_valid), 64'd1);
        check({tag, " rsp"}, 64'(rsp_pack()), 64'(exp));
    endtask

    logic [63:0] b2b_addr [4];
    logic [7:0]  b2b_exp  [4];

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset cfg_rvalid", 64'(cfg_rvalid), 64'd0);
        check("reset rsp", 64'(rsp_pack()), 64'd0);
        rst = 1'b0;

        cfg_read("attr r0 post-reset", 8'd4, 32'h0, 1'b0);
        lookup("miss post-reset", 64'h8000_0000, 2'd0, mk(1'b0, 3'd0, 3'b000, 1'b0));

        // r0 window with all attrs, r1 smaller window inside it
        cfg_write("r0 base_lo", 8'd0, 32'h8000_0000, 1'b0);
        cfg_write("r0 base_hi", 8'd1, 32'h0, 1'b0);
        cfg_write("r0 len_lo", 8'd2, 32'h1000_0000, 1'b0);
        cfg_write("r0 attr", 8'd4, 32'h0000_000F, 1'b0);
        cfg_write("r1 base_lo", 8'd8, 32'h8000_0000, 1'b0);
        cfg_write("r1 len_lo", 8'd10, 32'h0800_0000, 1'b0);
        cfg_write("r1 attr", 8'd12, 32'h0000_0009, 1'b0);
        cfg_read("r0 base_lo rb", 8'd0, 32'h8000_0000, 1'b0);
        lookup("overlap r0 wins", 64'h8000_0010, 2'd0, mk(1'b1, 3'd0, 3'b111, 1'b0));
        lookup("r0 last byte", 64'h8FFF_FFFF, 2'd2, mk(1'b1, 3'd0, 3'b111, 1'b0));
        lookup("r0 end miss", 64'h9000_0000, 2'd0, mk(1'b0, 3'd0, 3'b000, 1'b0));

        // r2 reaching 2^64, r3 enabled with zero length
        cfg_write("r2 base_lo", 8'd16, 32'hFFFF_F000, 1'b0);
        cfg_write("r2 base_hi", 8'd17, 32'hFFFF_FFFF, 1'b0);
        cfg_write("r2 len_lo", 8'd18, 32'h0000_1000, 1'b0);
        cfg_write("r2 attr", 8'd20, 32'h0000_000C, 1'b0);
        cfg_read("r2 base_hi rb", 8'd17, 32'hFFFF_FFFF, 1'b0);
        lookup("top address", 64'hFFFF_FFFF_FFFF_FFFF, 2'd0, mk(1'b1, 3'd2, 3'b100, 1'b0));
        lookup("below r2", 64'hFFFF_FFFF_FFFF_EFFF, 2'd0, mk(1'b0, 3'd0, 3'b000, 1'b0));
        cfg_write("r3 attr en len0", 8'd28, 32'h0000_000F, 1'b0);
        lookup("len0 never hits", 64'h0, 2'd0, mk(1'b0, 3'd0, 3'b000, 1'b0));

        // r1 moved out of r0: nonidem, not executable
        cfg_write("r1 base_lo move", 8'd8, 32'hA000_0000, 1'b0);
        cfg_write("r1 len_lo move", 8'd10, 32'h0000_1000, 1'b0);
        cfg_write("r1 attr nonidem", 8'd12, 32'h0000_000A, 1'b0);
        cfg_write("fcnt clear0", 8'd32, 32'h1234_5678, 1'b0);
        lookup("fetch noexec", 64'hA000_0000, 2'd2, mk(1'b1, 3'd1, 3'b010, 1'b1));
        lookup("amo nonidem", 64'hA000_0FFF, 2'd3, mk(1'b1, 3'd1, 3'b010, 1'b1));
        lookup("load ok", 64'hA000_0004, 2'd0, mk(1'b1, 3'd1, 3'b010, 1'b0));
        cfg_read("fcnt is 2", 8'd32, 32'd2, 1'b0);
        cfg_write("fcnt clear", 8'd32, 32'hFFFF_FFFF, 1'b0);
        cfg_read("fcnt is 0", 8'd32, 32'd0, 1'b0);

        // Locking r0
        cfg_write("r0 lock", 8'd4, 32'h8000_0008, 1'b0);
        cfg_write("r0 locked wr", 8'd0, 32'h0000_1234, 1'b1);
        cfg_write("r0 unlock try", 8'd4, 32'h0000_000F, 1'b1);
        cfg_read("r0 base_lo kept", 8'd0, 32'h8000_0000, 1'b0);
        cfg_read("r0 attr kept", 8'd4, 32'h8000_0008, 1'b0);
        cfg_write("undef idx wr", 8'hFF, 32'h1, 1'b1);
        cfg_read("undef idx rd", 8'hFF, 32'h0, 1'b1);
        cfg_read("undef word rd", 8'd5, 32'h0, 1'b1);
        lookup("locked r0 attrs", 64'h8000_0010, 2'd0, mk(1'b1, 3'd0, 3'b000, 1'b0));

        // Back-to-back stream with 3-cycle response stall
        b2b_addr[0] = 64'h8000_0010;          b2b_exp[0] = mk(1'b1, 3'd0, 3'b000, 1'b0);
        b2b_addr[1] = 64'h9000_0000;          b2b_exp[1] = mk(1'b0, 3'd0, 3'b000, 1'b0);
        b2b_addr[2] = 64'hFFFF_FFFF_FFFF_FFFF; b2b_exp[2] = mk(1'b1, 3'd2, 3'b100, 1'b0);
        b2b_addr[3] = 64'hA000_0000;          b2b_exp[3] = mk(1'b1, 3'd1, 3'b010, 1'b0);
        begin
            int sent = 0;
            int got = 0;
            logic       prev_stall = 1'b0;
            logic [7:0] prev_rsp = '0;
            @(posedge clk); #1;
            req_valid = 1'b1; req_addr = b2b_addr[0]; req_kind = 2'd0; rsp_ready = 1'b1;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                logic acc;
                @(negedge clk);
                acc = req_valid && req_ready;
                if (prev_stall) check($sformatf("b2b hold c%0d", cyc), 64'(rsp_pack()), 64'(prev_rsp));
                prev_stall = rsp_valid && !rsp_ready;
                prev_rsp = rsp_pack();
                if (prev_stall) check($sformatf("b2b ready low c%0d", cyc), 64'(req_ready), 64'd0);
                if (rsp_valid && rsp_ready) begin
                    check($sformatf("b2b rsp%0d", got), 64'(rsp_pack()), 64'(b2b_exp[got]));
                    got++;
                end
                @(posedge clk); #1;
                if (acc) sent++;
                req_valid = (sent < 4);
                if (sent < 4) req_addr = b2b_addr[sent];
                rsp_ready = !(cyc >= 1 && cyc <= 3);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            check("b2b responses", 64'(got), 64'd4);
        end

        // Reset with a lookup in flight
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 64'h8000_0010; req_kind = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid reset rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                if (rsp_valid) seen++;
            end
            check("dropped lookup", 64'(seen), 64'd0);
        end
        cfg_read("config lost", 8'd0, 32'h0, 1'b0);
        cfg_write("lock lost", 8'd0, 32'h1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
